// File: rtl/frame_config_pkg.sv
// Shared types and constants for the frame configuration controller.
// Command word layout: [31:24] opcode, [15:8] column, [4:0] frame.
package frame_config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_END   = 8'h02;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam int COL_HI = 15;
  localparam int COL_LO = 8;
  localparam int FRM_HI = 4;
  localparam int FRM_LO = 0;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_config_ctrl_strobe_decoder.sv
// Column/frame address to one-hot frame strobe.
// Out-of-range addresses decode to all zeros.
module frame_strobe_decoder #(
  parameter int NumColumns      = 4,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                  en,
  input  logic [7:0]                            col,
  input  logic [4:0]                            frame,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

  always_comb begin
    strobe = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        strobe[c*MaxFramesPerCol+f] =
          en && (col == 8'(c)) && (frame == 5'(f));
      end
    end
  end

endmodule

// File: rtl/frame_config_ctrl.sv
// Bitstream-to-frame-write controller: SYNC, WRITE/END/NOP commands,
// row payload capture (top row first), then a setup and a strobe cycle.
module frame_config_ctrl
  import frame_config_pkg::*;
#(
  parameter int          NumColumns      = 4,
  parameter int          NumRows         = 4,
  parameter int          MaxFramesPerCol = 20,
  parameter int          FrameBitsPerRow = 32,
  parameter logic [31:0] SyncWord        = SYNC_WORD_DEFAULT
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [31:0]                           s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  MODE,
  output logic                                  conf_done,
  output logic                                  conf_error,
  output logic [15:0]                           frame_count
);

  localparam int         RowW   = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [7:0] ColLim = 8'(NumColumns);
  localparam logic [4:0] FrmLim = 5'(MaxFramesPerCol);

  state_e                         state_q, state_d;
  logic [NumRows*FrameBitsPerRow-1:0] data_q, data_d;
  logic [RowW-1:0]                row_q, row_d;
  logic [7:0]                     col_q, col_d;
  logic [4:0]                     frm_q, frm_d;
  logic                           mode_q, mode_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic [15:0]                    cnt_q, cnt_d;

  logic       fire;
  logic       is_sync;
  logic [7:0] opc;
  logic [7:0] cmd_col;
  logic [4:0] cmd_frm;

  assign s_ready = (state_q != ST_SETUP) && (state_q != ST_STROBE);
  assign fire    = s_valid && s_ready;
  assign is_sync = (s_data == SyncWord);
  assign opc     = s_data[OPC_HI:OPC_LO];
  assign cmd_col = s_data[COL_HI:COL_LO];
  assign cmd_frm = s_data[FRM_HI:FRM_LO];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    row_d   = row_q;
    col_d   = col_q;
    frm_d   = frm_q;
    mode_d  = mode_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (fire && is_sync) begin
          state_d = ST_CMD;
          mode_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_CMD: begin
        if (fire) begin
          unique case (opc)
            OP_NOP: ;
            OP_WRITE: begin
              if (cmd_col < ColLim && cmd_frm < FrmLim) begin
                state_d = ST_DATA;
                col_d   = cmd_col;
                frm_d   = cmd_frm;
                row_d   = RowW'(NumRows - 1);
              end else begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
              end
            end
            OP_END: begin
              state_d = ST_DONE;
              mode_d  = 1'b0;
              done_d  = 1'b1;
            end
            default: begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_DATA: begin
        if (fire) begin
          data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
          if (row_q == '0) state_d = ST_SETUP;
          else row_d = row_q - 1'b1;
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        state_d = ST_CMD;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      frm_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frm_q   <= frm_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  frame_strobe_decoder #(
    .NumColumns     (NumColumns),
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_dec (
    .en    (state_q == ST_STROBE),
    .col   (col_q),
    .frame (frm_q),
    .strobe(FrameStrobe)
  );

  assign FrameData   = data_q;
  assign MODE        = mode_q;
  assign conf_done   = done_q;
  assign conf_error  = err_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Scenario bench for frame_config_ctrl with a strobe scoreboard.
// Expected strobes are queued on the last data accept and popped on strobe.
module tb_frame_config_ctrl;

  localparam int NC = 4;
  localparam int NR = 4;
  localparam int MF = 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic           CLK = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [NR*32-1:0] FrameData;
  logic [NC*MF-1:0] FrameStrobe;
  logic           MODE;
  logic           conf_done;
  logic           conf_error;
  logic [15:0]    frame_count;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          idx;
    logic [127:0] data;
    longint      t;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  frame_config_ctrl dut (
    .CLK        (CLK),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .MODE       (MODE),
    .conf_done  (conf_done),
    .conf_error (conf_error),
    .frame_count(frame_count)
  );

  // Strobe monitor: every nonzero strobe must match the scoreboard head.
  always @(negedge CLK) begin
    if (!reset && FrameStrobe != '0) begin
      logic [NC*MF-1:0] es;
      total++;
      if ($countones(FrameStrobe) != 1)
        $display("FAIL onehot: got %h", FrameStrobe);
      else passed++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got %h want none", FrameStrobe);
      end else begin
        exp_t e;
        e = sb.pop_front();
        es = '0;
        es[e.idx] = 1'b1;
        total += 3;
        if (FrameStrobe !== es)
          $display("FAIL strobe_idx: got %h want %h", FrameStrobe, es);
        else passed++;
        if (FrameData !== e.data)
          $display("FAIL frame_data: got %h want %h", FrameData, e.data);
        else passed++;
        if ($time != e.t)
          $display("FAIL strobe_time: got %0d want %0d", $time, e.t);
        else passed++;
      end
    end
  end

  logic [127:0] last_data;
  longint       last_acc;

  task automatic send(input logic [31:0] w);
    int n = 0;
    @(negedge CLK);
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n == 20) begin
      total++;
      $display("FAIL ready_timeout: got s_ready=0 want 1");
    end
    @(posedge CLK);
    last_acc = $time;
    #1 s_valid = 1'b0;
  endtask

  function automatic logic [31:0] wr(input int c, input int f);
    logic [7:0] cc = 8'(c);
    logic [4:0] ff = 5'(f);
    return {8'h01, 8'h00, cc, 3'b000, ff};
  endfunction

  task automatic send_frame(input int c, input int f,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input bit gaps);
    logic [31:0] w[4];
    exp_t e;
    w[0] = d0; w[1] = d1; w[2] = d2; w[3] = d3;
    send(wr(c, f));
    for (int i = 0; i < 4; i++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 2)) @(negedge CLK);
      send(w[i]);
    end
    last_data = {d0, d1, d2, d3};
    e.idx  = c * MF + f;
    e.data = last_data;
    e.t    = last_acc + 15;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    s_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({s_ready, MODE, conf_done, conf_error} !== 4'b1000)
      $display("FAIL reset_flags: got %b want 1000",
               {s_ready, MODE, conf_done, conf_error});
    else passed++;
    total++;
    if (FrameData !== '0 || FrameStrobe !== '0 || frame_count !== 16'd0)
      $display("FAIL reset_data: got %h/%h/%0d want 0",
               FrameData, FrameStrobe, frame_count);
    else passed++;
  endtask

  task automatic test_garbage();
    repeat (3) send(32'h1234_5678);
    repeat (2) @(negedge CLK);
    total++;
    if (MODE !== 1'b0 || conf_done !== 1'b0)
      $display("FAIL garbage_mode: got %b%b want 00", MODE, conf_done);
    else passed++;
  endtask

  task automatic test_basic();
    send(SYNC);
    @(negedge CLK);
    total++;
    if (MODE !== 1'b1)
      $display("FAIL sync_mode: got %b want 1", MODE);
    else passed++;
    send_frame(1, 3, 32'hA0A0_0000, 32'hA1A1_1111,
               32'hA2A2_2222, 32'hA3A3_3333, 1'b0);
    repeat (4) @(negedge CLK);
    total++;
    if (frame_count !== 16'd1)
      $display("FAIL basic_count: got %0d want 1", frame_count);
    else passed++;
    total++;
    if (FrameData[127:96] !== 32'hA0A0_0000 || FrameData !== last_data)
      $display("FAIL basic_hold: got %h want %h", FrameData, last_data);
    else passed++;
    send(32'h0200_0000);
    @(negedge CLK);
    total++;
    if (MODE !== 1'b0 || conf_done !== 1'b1)
      $display("FAIL end_flags: got %b%b want 01", MODE, conf_done);
    else passed++;
    send(32'h1234_5678);
    send(SYNC);
    @(negedge CLK);
    total++;
    if ({MODE, conf_done, frame_count} !== {2'b10, 16'd0})
      $display("FAIL reconf: got %b%b/%0d want 10/0",
               MODE, conf_done, frame_count);
    else passed++;
  endtask

  task automatic test_errors();
    do_reset();
    send(SYNC);
    send(wr(4, 0));
    @(negedge CLK);
    total++;
    if (conf_error !== 1'b1 || MODE !== 1'b1)
      $display("FAIL err_col: got %b%b want 11", conf_error, MODE);
    else passed++;
    do_reset();
    send(SYNC);
    send(32'h0700_0000);
    @(negedge CLK);
    total++;
    if (conf_error !== 1'b1)
      $display("FAIL err_opc: got %b want 1", conf_error);
    else passed++;
    send(32'h0000_0000);
    send(SYNC);
    send_frame(2, 5, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
    repeat (4) @(negedge CLK);
    total++;
    if (conf_error !== 1'b1 || frame_count !== 16'd1)
      $display("FAIL err_sticky: got %b/%0d want 1/1",
               conf_error, frame_count);
    else passed++;
  endtask

  task automatic test_gaps();
    do_reset();
    send(SYNC);
    send(32'h0000_0000);
    send_frame(2, 7, 32'hDEAD_BEEF, 32'hCAFE_F00D,
               32'h0BAD_F00D, 32'h8BAD_BEEF, 1'b1);
    @(negedge CLK);
    total++;
    if (s_ready !== 1'b0)
      $display("FAIL gap_setup_rdy: got %b want 0", s_ready);
    else passed++;
    @(negedge CLK);
    total++;
    if (s_ready !== 1'b0 || FrameStrobe === '0)
      $display("FAIL gap_strobe_rdy: got %b want 0", s_ready);
    else passed++;
    @(negedge CLK);
    total++;
    if (s_ready !== 1'b1 || FrameStrobe !== '0)
      $display("FAIL gap_after: got %b/%h want 1/0", s_ready, FrameStrobe);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(SYNC);
    send(wr(1, 1));
    send(32'h5555_5555);
    send(32'h6666_6666);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    total++;
    if (FrameStrobe !== '0 || FrameData !== '0 || MODE !== 1'b0)
      $display("FAIL mid_reset: got %h/%h/%b want 0",
               FrameStrobe, FrameData, MODE);
    else passed++;
    @(negedge CLK);
    reset = 1'b0;
    repeat (6) @(negedge CLK);
    total++;
    if (FrameData !== '0 || frame_count !== 16'd0)
      $display("FAIL mid_after: got %h/%0d want 0", FrameData, frame_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(SYNC);
    send_frame(0, 0, 32'h1111_0000, 32'h2222_0000,
               32'h3333_0000, 32'h4444_0000, 1'b0);
    send_frame(3, 19, 32'h0000_AAAA, 32'h0000_BBBB,
               32'h0000_CCCC, 32'h0000_DDDD, 1'b0);
    repeat (4) @(negedge CLK);
    total++;
    if (frame_count !== 16'd2)
      $display("FAIL b2b_count: got %0d want 2", frame_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_garbage();
    test_basic();
    test_errors();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    total++;
    if (sb.size() != 0)
      $display("FAIL missing_strobes: got %0d pending want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
